// File: rtl/dcache_hit_write.sv
// Store-hit write path of the dcache: registers one store hit, performs a strobed
// 128b bank write, then sets the line dirty bit, touches PLRU and reports completion.
module dcache_hit_write #(
    parameter int INDEX_W = 6,
    parameter int WAY_W   = 3
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               ctrl2hit_write_valid,
    output logic               hit_write2ctrl_ready,
    input  logic [INDEX_W-1:0] ctrl2hit_write_index,
    input  logic [WAY_W-1:0]   ctrl2hit_write_way,
    input  logic [5:0]         ctrl2hit_write_offset,
    input  logic [63:0]        ctrl2hit_write_wdata,
    input  logic [7:0]         ctrl2hit_write_wstrb,
    output logic               hit_write2ctrl_done,

    output logic               hit_write2data_array_valid,
    input  logic               data_array2hit_write_ready,
    output logic [INDEX_W-1:0] hit_write2data_array_index,
    output logic [WAY_W-1:0]   hit_write2data_array_way,
    output logic [1:0]         hit_write2data_array_offset,
    output logic [127:0]       hit_write2data_array_wdata,
    output logic [15:0]        hit_write2data_array_wstrb,

    output logic               hit_write2dirty_valid,
    output logic [INDEX_W-1:0] hit_write2dirty_index,
    output logic [WAY_W-1:0]   hit_write2dirty_way,

    output logic               hit_write2plru_valid,
    output logic [INDEX_W-1:0] hit_write2plru_index,
    output logic [WAY_W-1:0]   hit_write2plru_way
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [INDEX_W-1:0] req_index_reg;
    logic [WAY_W-1:0]   req_way_reg;
    logic [2:0]         req_offset_reg;   // offset[5:3]: bank select and 8B half
    logic [63:0]        req_wdata_reg;
    logic [7:0]         req_wstrb_reg;

    logic               accept;
    logic               bank_handshake;

    // ctrl pre-aligns data to the 8B lane, so the low offset bits carry no information.
    logic               unused_offset_bits;
    assign unused_offset_bits = ^ctrl2hit_write_offset[2:0];

    assign accept         = (state_reg == IDLE) && ctrl2hit_write_valid;
    assign bank_handshake = (state_reg == WRITE) && data_array2hit_write_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            req_index_reg  <= '0;
            req_way_reg    <= '0;
            req_offset_reg <= '0;
            req_wdata_reg  <= '0;
            req_wstrb_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                req_index_reg  <= ctrl2hit_write_index;
                req_way_reg    <= ctrl2hit_write_way;
                req_offset_reg <= ctrl2hit_write_offset[5:3];
                req_wdata_reg  <= ctrl2hit_write_wdata;
                req_wstrb_reg  <= ctrl2hit_write_wstrb;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ctrl2hit_write_valid) begin
                    state_next = (ctrl2hit_write_wstrb != 8'h00) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (data_array2hit_write_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign hit_write2ctrl_ready = (state_reg == IDLE);
    assign hit_write2ctrl_done  = (state_reg == DONE);

    assign hit_write2data_array_valid  = (state_reg == WRITE);
    assign hit_write2data_array_index  = req_index_reg;
    assign hit_write2data_array_way    = req_way_reg;
    assign hit_write2data_array_offset = req_offset_reg[2:1];

    // The 8B store lands in either half of the 16B bank; data is replicated to both.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign hit_write2data_array_wdata[gi*64 +: 64] = req_wdata_reg;
            assign hit_write2data_array_wstrb[gi*8 +: 8]   =
                (req_offset_reg[0] == 1'(gi)) ? req_wstrb_reg : 8'h00;
        end
    endgenerate

    assign hit_write2dirty_valid = bank_handshake;
    assign hit_write2dirty_index = req_index_reg;
    assign hit_write2dirty_way   = req_way_reg;

    // A zero-strobe store touches PLRU in its DONE cycle, once the registered index is valid.
    assign hit_write2plru_valid = bank_handshake ||
                                  ((state_reg == DONE) && (req_wstrb_reg == 8'h00));
    assign hit_write2plru_index = req_index_reg;
    assign hit_write2plru_way   = req_way_reg;

endmodule

// File: tb/tb_dcache_hit_write.sv
// Directed bench for dcache_hit_write: hand-computed expectations checked one cycle at a time.
module tb_dcache_hit_write;

    localparam int INDEX_W = 6;
    localparam int WAY_W   = 3;

    logic               clock;
    logic               reset;
    logic               c_valid;
    logic               c_ready;
    logic [INDEX_W-1:0] c_index;
    logic [WAY_W-1:0]   c_way;
    logic [5:0]         c_offset;
    logic [63:0]        c_wdata;
    logic [7:0]         c_wstrb;
    logic               c_done;
    logic               da_valid;
    logic               da_ready;
    logic [INDEX_W-1:0] da_index;
    logic [WAY_W-1:0]   da_way;
    logic [1:0]         da_offset;
    logic [127:0]       da_wdata;
    logic [15:0]        da_wstrb;
    logic               dirty_valid;
    logic [INDEX_W-1:0] dirty_index;
    logic [WAY_W-1:0]   dirty_way;
    logic               plru_valid;
    logic [INDEX_W-1:0] plru_index;
    logic [WAY_W-1:0]   plru_way;

    int checks   = 0;
    int failures = 0;

    dcache_hit_write #(.INDEX_W(INDEX_W), .WAY_W(WAY_W)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .ctrl2hit_write_valid        (c_valid),
        .hit_write2ctrl_ready        (c_ready),
        .ctrl2hit_write_index        (c_index),
        .ctrl2hit_write_way          (c_way),
        .ctrl2hit_write_offset       (c_offset),
        .ctrl2hit_write_wdata        (c_wdata),
        .ctrl2hit_write_wstrb        (c_wstrb),
        .hit_write2ctrl_done         (c_done),
        .hit_write2data_array_valid  (da_valid),
        .data_array2hit_write_ready  (da_ready),
        .hit_write2data_array_index  (da_index),
        .hit_write2data_array_way    (da_way),
        .hit_write2data_array_offset (da_offset),
        .hit_write2data_array_wdata  (da_wdata),
        .hit_write2data_array_wstrb  (da_wstrb),
        .hit_write2dirty_valid       (dirty_valid),
        .hit_write2dirty_index       (dirty_index),
        .hit_write2dirty_way         (dirty_way),
        .hit_write2plru_valid        (plru_valid),
        .hit_write2plru_index        (plru_index),
        .hit_write2plru_way          (plru_way)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request while IDLE, let it be accepted, then drop valid.
    task automatic issue(input logic [5:0] idx, input logic [2:0] way, input logic [5:0] off,
                         input logic [63:0] wd, input logic [7:0] ws);
        c_valid  = 1'b1;
        c_index  = idx;
        c_way    = way;
        c_offset = off;
        c_wdata  = wd;
        c_wstrb  = ws;
        #1;
        check("ready_before_accept", c_ready, 1'b1);
        tick();
        c_valid = 1'b0;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_da_valid"}, da_valid, 1'b0);
        check({tag, "_dirty"}, dirty_valid, 1'b0);
        check({tag, "_plru"}, plru_valid, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        c_valid  = 1'b0;
        c_index  = '0;
        c_way    = '0;
        c_offset = '0;
        c_wdata  = '0;
        c_wstrb  = '0;
        da_ready = 1'b1;
        tick();
        tick();
        $display("reset state");
        check("rst_ready", c_ready, 1'b1);
        check("rst_done", c_done, 1'b0);
        check_quiet("rst");
        check("rst_da_index", da_index, 6'd0);
        check("rst_da_wdata", da_wdata, 128'h0);
        reset = 1'b0;
        tick();

        // 1: full-lane store into upper half of bank 0, ready tied high
        $display("txn1 idx=5 way=3 off=08 wstrb=ff");
        issue(6'd5, 3'd3, 6'h08, 64'h1122334455667788, 8'hFF);
        check("t1_da_valid", da_valid, 1'b1);
        check("t1_da_index", da_index, 6'd5);
        check("t1_da_way", da_way, 3'd3);
        check("t1_da_offset", da_offset, 2'd0);
        check("t1_da_wstrb", da_wstrb, 16'hFF00);
        check("t1_da_wdata", da_wdata, 128'h1122334455667788_1122334455667788);
        check("t1_dirty_valid", dirty_valid, 1'b1);
        check("t1_dirty_idx", {dirty_index, dirty_way}, {6'd5, 3'd3});
        check("t1_plru_valid", plru_valid, 1'b1);
        check("t1_plru_idx", {plru_index, plru_way}, {6'd5, 3'd3});
        check("t1_done_early", c_done, 1'b0);
        tick();
        check("t1_done", c_done, 1'b1);
        check("t1_ready_in_done", c_ready, 1'b0);
        check_quiet("t1_done");
        tick();
        check("t1_ready_back", c_ready, 1'b1);
        check("t1_done_once", c_done, 1'b0);

        // 2: lower half of bank 3
        $display("txn2 idx=7 way=6 off=30 wstrb=0f");
        issue(6'd7, 3'd6, 6'h30, 64'hA5A5A5A5_5A5A5A5A, 8'h0F);
        check("t2_da_offset", da_offset, 2'd3);
        check("t2_da_wstrb", da_wstrb, 16'h000F);
        check("t2_dirty_idx", {dirty_valid, dirty_index, dirty_way}, {1'b1, 6'd7, 3'd6});
        tick();
        check("t2_done", c_done, 1'b1);
        tick();

        // 3: data_array stalls for 4 cycles
        $display("txn3 idx=12 way=2 off=18 wstrb=3c stall=4");
        da_ready = 1'b0;
        issue(6'd12, 3'd2, 6'h18, 64'hDEADBEEF_CAFEF00D, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            check("t3_stall_da_valid", da_valid, 1'b1);
            check("t3_stall_payload", {da_index, da_way, da_offset, da_wstrb},
                  {6'd12, 3'd2, 2'd1, 16'h3C00});
            check("t3_stall_wdata", da_wdata, 128'hDEADBEEF_CAFEF00D_DEADBEEF_CAFEF00D);
            check("t3_stall_dirty", dirty_valid, 1'b0);
            check("t3_stall_plru", plru_valid, 1'b0);
            check("t3_stall_done", c_done, 1'b0);
            if (i < 3) tick();
        end
        da_ready = 1'b1;
        #1;
        check("t3_hs_dirty", {dirty_valid, dirty_index, dirty_way}, {1'b1, 6'd12, 3'd2});
        check("t3_hs_plru", {plru_valid, plru_index, plru_way}, {1'b1, 6'd12, 3'd2});
        tick();
        check("t3_done", c_done, 1'b1);
        check_quiet("t3_done");
        tick();

        // 4: zero strobe skips the bank write and dirty set
        $display("txn4 idx=9 way=1 wstrb=00");
        issue(6'd9, 3'd1, 6'h00, 64'h0, 8'h00);
        check("t4_da_valid", da_valid, 1'b0);
        check("t4_dirty", dirty_valid, 1'b0);
        check("t4_plru", {plru_valid, plru_index, plru_way}, {1'b1, 6'd9, 3'd1});
        check("t4_done", c_done, 1'b1);
        tick();
        check("t4_ready_back", c_ready, 1'b1);
        check("t4_done_once", c_done, 1'b0);
        check_quiet("t4_idle");

        // 5: second request held during WRITE is accepted only after IDLE
        $display("txn5 held request during write");
        da_ready = 1'b0;
        c_valid  = 1'b1;
        c_index  = 6'd20;
        c_way    = 3'd4;
        c_offset = 6'h20;
        c_wdata  = 64'h0102030405060708;
        c_wstrb  = 8'h80;
        tick();
        c_index  = 6'd33;
        c_way    = 3'd7;
        c_offset = 6'h08;
        c_wdata  = 64'hFFEEDDCCBBAA9988;
        c_wstrb  = 8'h01;
        #1;
        check("t5_ready_busy", c_ready, 1'b0);
        check("t5_first_addr", {da_index, da_way, da_offset, da_wstrb}, {6'd20, 3'd4, 2'd2, 16'h0080});
        tick();
        check("t5_first_held", {da_valid, da_index, da_way}, {1'b1, 6'd20, 3'd4});
        da_ready = 1'b1;
        #1;
        check("t5_first_dirty", {dirty_valid, dirty_index, dirty_way}, {1'b1, 6'd20, 3'd4});
        tick();
        check("t5_done", c_done, 1'b1);
        check("t5_ready_done", c_ready, 1'b0);
        check("t5_plru_done", plru_valid, 1'b0);
        tick();
        check("t5_idle_ready", c_ready, 1'b1);
        tick();
        c_valid = 1'b0;
        #1;
        check("t5_second_addr", {da_valid, da_index, da_way, da_offset, da_wstrb},
              {1'b1, 6'd33, 3'd7, 2'd0, 16'h0100});
        check("t5_second_wdata", da_wdata, 128'hFFEEDDCCBBAA9988_FFEEDDCCBBAA9988);
        check("t5_second_dirty", {dirty_valid, dirty_index, dirty_way}, {1'b1, 6'd33, 3'd7});
        tick();
        check("t5_second_done", c_done, 1'b1);
        tick();

        // 6: reset while a store waits in WRITE
        $display("txn6 reset during write idx=40 way=5");
        da_ready = 1'b0;
        issue(6'd40, 3'd5, 6'h10, 64'h55AA55AA55AA55AA, 8'hFF);
        check("t6_in_write", da_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        da_ready = 1'b1;
        #1;
        check("t6_ready", c_ready, 1'b1);
        check("t6_done", c_done, 1'b0);
        check_quiet("t6_rst");
        check("t6_req_cleared", {da_index, da_way}, {6'd0, 3'd0});
        tick();
        check("t6_after_done", c_done, 1'b0);
        check_quiet("t6_after");
        check("t6_after_ready", c_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
